ring_osc_freq_counter: RTL

RING_OSC_FREQ_COUNTER -- requirements
Module: ring_osc_freq_counter

---
 rtl/ring_osc_freq_counter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ring_osc_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of osc_in
// over a gate window of 2^GATE_LOG2 clk cycles and holds the saturating result.
module ring_osc_freq_counter #(
    parameter int GATE_LOG2 = 10,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       osc_in,
    input  logic       start,
    input  logic       byte_sel,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic [7:0] count_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_LOG2-1:0] TIMER_LAST = {GATE_LOG2{1'b1}};
    localparam logic [GATE_LOG2-1:0] TIMER_ONE  = {{(GATE_LOG2-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic                 s1_q, s2_q, s3_q;
    logic                 edge_s;
    logic                 sat_s;
    logic [GATE_LOG2-1:0] timer_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CNT_W-1:0]     result_q;
    logic                 ovf_q;
    logic [15:0]          result_ext_s;

    // Synchronizer chain plus edge-history flop; free-running, never cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= osc_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_s = s2_q & ~s3_q;

    // Saturating next value of the edge counter for the current cycle.
    always_comb begin
        sat_s = (cnt_q == CNT_MAX);
        if (edge_s && !sat_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Measurement FSM with gate timer, edge counter, result and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= {GATE_LOG2{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        timer_q <= {GATE_LOG2{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                        ovf_q   <= 1'b0;
                        state_q <= ST_GATE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_GATE: begin
                    timer_q <= timer_q + TIMER_ONE;
                    cnt_q   <= cnt_d;
                    if (edge_s && sat_s) begin
                        ovf_q <= 1'b1;
                    end else begin
                        ovf_q <= ovf_q;
                    end
                    // The final gate cycle's edge is already folded into cnt_d.
                    if (timer_q == TIMER_LAST) begin
                        result_q <= cnt_d;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q  <= ST_GATE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == ST_GATE);
    assign done = (state_q == ST_DONE);
    assign ovf  = ovf_q;

    // Zero-extend the result to 16 bits and select the requested byte.
    always_comb begin
        result_ext_s             = 16'd0;
        result_ext_s[CNT_W-1:0]  = result_q;
        if (byte_sel) begin
            count_out = result_ext_s[15:8];
        end else begin
            count_out = result_ext_s[7:0];
        end
    end

endmodule
